// File: rtl/cr_clic_cpu_intc.sv
// CPU-side CLIC request receiver: qualifies requests, raises a precise trap, and
// redirects the IFU, reading the vector table first for hardware-vectored interrupts.
module cr_clic_cpu_intc #(
    parameter int ID_WIDTH = 12,
    parameter int IL_WIDTH = 8
) (
    input  logic                forever_cpuclk,
    input  logic                cpurst_b,
    input  logic                clic_cpu_int_hv,
    input  logic [ID_WIDTH-1:0] clic_cpu_int_id,
    input  logic [IL_WIDTH-1:0] clic_cpu_int_il,
    input  logic [1:0]          clic_cpu_int_priv,
    input  logic [1:0]          cp0_intc_mode,
    input  logic                cp0_intc_mie,
    input  logic [IL_WIDTH-1:0] cp0_intc_mil,
    input  logic [31:0]         cp0_intc_mtvec,
    input  logic [31:0]         cp0_intc_mtvt,
    output logic                intc_rtu_int_req,
    output logic [ID_WIDTH-1:0] intc_rtu_int_id,
    output logic [IL_WIDTH-1:0] intc_rtu_int_il,
    input  logic                rtu_intc_int_ack,
    output logic                intc_biu_vec_req,
    output logic [31:0]         intc_biu_vec_addr,
    input  logic                biu_intc_vec_gnt,
    input  logic                biu_intc_vec_rvld,
    input  logic [31:0]         biu_intc_vec_rdata,
    input  logic                biu_intc_vec_err,
    output logic                intc_ifu_jump_vld,
    output logic [31:0]         intc_ifu_jump_pc,
    output logic                intc_ifu_vec_err,
    output logic [ID_WIDTH-1:0] cpu_clic_curid,
    output logic                cpu_clic_int_exit,
    output logic [1:0]          cpu_clic_mode
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_VREQ  = 3'd2,
        ST_VWAIT = 3'd3,
        ST_JUMP  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ID_WIDTH-1:0] id_q;
    logic [IL_WIDTH-1:0] il_q;
    logic                hv_q;
    logic [ID_WIDTH-1:0] curid_q;
    logic                exit_q;
    logic [31:0]         vec_addr_q;
    logic [31:0]         pc_q;
    logic                vec_err_q;
    logic [1:0]          mode_q;

    logic eligible;
    logic latch_en;
    logic take;
    logic rsp_take;

    // U-mode code is always preemptible by M-mode interrupts regardless of MIE/mil
    assign eligible = (clic_cpu_int_il != '0) && (clic_cpu_int_priv == 2'b11) &&
                      ((cp0_intc_mode == 2'b00) ||
                       (cp0_intc_mie && (clic_cpu_int_il > cp0_intc_mil)));

    assign take     = (state_q == ST_REQ) && rtu_intc_int_ack;
    assign latch_en = eligible && ((state_q == ST_IDLE) || ((state_q == ST_REQ) && !rtu_intc_int_ack));
    assign rsp_take = biu_intc_vec_rvld &&
                      (((state_q == ST_VREQ) && biu_intc_vec_gnt) || (state_q == ST_VWAIT));

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (eligible) state_d = ST_REQ;
            ST_REQ: begin
                if (rtu_intc_int_ack)  state_d = hv_q ? ST_VREQ : ST_JUMP;
                else if (!eligible)    state_d = ST_IDLE;
            end
            ST_VREQ:  if (biu_intc_vec_gnt) state_d = biu_intc_vec_rvld ? ST_JUMP : ST_VWAIT;
            ST_VWAIT: if (biu_intc_vec_rvld) state_d = ST_JUMP;
            ST_JUMP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            id_q       <= '0;
            il_q       <= '0;
            hv_q       <= 1'b0;
            curid_q    <= '0;
            exit_q     <= 1'b0;
            vec_addr_q <= '0;
            pc_q       <= '0;
            vec_err_q  <= 1'b0;
            mode_q     <= 2'b11;
        end else begin
            mode_q <= cp0_intc_mode;
            exit_q <= take;
            if (latch_en) begin
                id_q <= clic_cpu_int_id;
                il_q <= clic_cpu_int_il;
                hv_q <= clic_cpu_int_hv;
            end
            if (take) begin
                curid_q    <= id_q;
                vec_addr_q <= (cp0_intc_mtvt & 32'hFFFF_FFC0) +
                              {{(32-ID_WIDTH-2){1'b0}}, id_q, 2'b00};
                if (!hv_q) begin
                    pc_q      <= cp0_intc_mtvec;
                    vec_err_q <= 1'b0;
                end
            end
            // A faulted vector fetch falls back to the non-vectored trap base
            if (rsp_take) begin
                pc_q      <= biu_intc_vec_err ? cp0_intc_mtvec : (biu_intc_vec_rdata & 32'hFFFF_FFFE);
                vec_err_q <= biu_intc_vec_err;
            end
        end
    end

    always_comb begin
        intc_rtu_int_req  = (state_q == ST_REQ);
        intc_rtu_int_id   = (state_q == ST_REQ) ? id_q : '0;
        intc_rtu_int_il   = (state_q == ST_REQ) ? il_q : '0;
        intc_biu_vec_req  = (state_q == ST_VREQ);
        intc_biu_vec_addr = (state_q == ST_VREQ) ? vec_addr_q : 32'h0;
        intc_ifu_jump_vld = (state_q == ST_JUMP);
        intc_ifu_jump_pc  = (state_q == ST_JUMP) ? pc_q : 32'h0;
        intc_ifu_vec_err  = (state_q == ST_JUMP) && vec_err_q;
        cpu_clic_curid    = curid_q;
        cpu_clic_int_exit = exit_q;
        cpu_clic_mode     = mode_q;
    end

endmodule

// File: tb/tb_cr_clic_cpu_intc.sv
// Directed bench for cr_clic_cpu_intc: trap request/ack, preemption, withdraw,
// vectored fetch with wait states and error, and reset during an outstanding read.
module tb_cr_clic_cpu_intc;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        hv;
    logic [11:0] id;
    logic [7:0]  il;
    logic [1:0]  priv;
    logic [1:0]  mode;
    logic        mie;
    logic [7:0]  mil;
    logic [31:0] mtvec;
    logic [31:0] mtvt;
    logic        int_req;
    logic [11:0] int_id;
    logic [7:0]  int_il;
    logic        ack;
    logic        vec_req;
    logic [31:0] vec_addr;
    logic        gnt;
    logic        rvld;
    logic [31:0] rdata;
    logic        err;
    logic        jump_vld;
    logic [31:0] jump_pc;
    logic        jvec_err;
    logic [11:0] curid;
    logic        int_exit;
    logic [1:0]  cmode;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    cr_clic_cpu_intc dut (
        .forever_cpuclk     (clk),
        .cpurst_b           (rst_b),
        .clic_cpu_int_hv    (hv),
        .clic_cpu_int_id    (id),
        .clic_cpu_int_il    (il),
        .clic_cpu_int_priv  (priv),
        .cp0_intc_mode      (mode),
        .cp0_intc_mie       (mie),
        .cp0_intc_mil       (mil),
        .cp0_intc_mtvec     (mtvec),
        .cp0_intc_mtvt      (mtvt),
        .intc_rtu_int_req   (int_req),
        .intc_rtu_int_id    (int_id),
        .intc_rtu_int_il    (int_il),
        .rtu_intc_int_ack   (ack),
        .intc_biu_vec_req   (vec_req),
        .intc_biu_vec_addr  (vec_addr),
        .biu_intc_vec_gnt   (gnt),
        .biu_intc_vec_rvld  (rvld),
        .biu_intc_vec_rdata (rdata),
        .biu_intc_vec_err   (err),
        .intc_ifu_jump_vld  (jump_vld),
        .intc_ifu_jump_pc   (jump_pc),
        .intc_ifu_vec_err   (jvec_err),
        .cpu_clic_curid     (curid),
        .cpu_clic_int_exit  (int_exit),
        .cpu_clic_mode      (cmode)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_b = 1'b0; hv = 1'b0; id = '0; il = '0; priv = 2'b11;
        mode = 2'b11; mie = 1'b1; mil = 8'd3;
        mtvec = 32'h0000_8000; mtvt = 32'h2000_0047;
        ack = 1'b0; gnt = 1'b0; rvld = 1'b0; rdata = '0; err = 1'b0;
        step(); step();
        chk("rst_int_req", {31'b0, int_req}, 32'h0);
        chk("rst_jump_vld", {31'b0, jump_vld}, 32'h0);
        chk("rst_curid", {20'b0, curid}, 32'h0);
        chk("rst_mode", {30'b0, cmode}, 32'h3);
        rst_b = 1'b1;
        step();

        // Basic non-vectored trap
        id = 12'd17; il = 8'd5;
        step();
        chk("req_rise", {31'b0, int_req}, 32'h1);
        chk("req_id", {20'b0, int_id}, 32'd17);
        chk("req_il", {24'b0, int_il}, 32'd5);
        ack = 1'b1;
        step();
        ack = 1'b0; il = 8'd0;
        chk("ack_exit", {31'b0, int_exit}, 32'h1);
        chk("ack_curid", {20'b0, curid}, 32'd17);
        chk("ack_jump_vld", {31'b0, jump_vld}, 32'h1);
        chk("ack_jump_pc", jump_pc, 32'h0000_8000);
        chk("ack_req_drop", {31'b0, int_req}, 32'h0);
        step();
        chk("exit_1cyc", {31'b0, int_exit}, 32'h0);
        chk("jump_1cyc", {31'b0, jump_vld}, 32'h0);
        chk("curid_hold", {20'b0, curid}, 32'd17);

        // Level equal to mil is not eligible in M mode, but is in U mode
        id = 12'd8; il = 8'd3;
        step();
        chk("il_eq_mil", {31'b0, int_req}, 32'h0);
        priv = 2'b01; mode = 2'b00;
        step();
        chk("priv_s_ignored", {31'b0, int_req}, 32'h0);
        chk("mode_copy_u", {30'b0, cmode}, 32'h0);
        priv = 2'b11;
        step();
        chk("umode_req", {31'b0, int_req}, 32'h1);

        // Withdraw without ack
        il = 8'd0;
        step();
        chk("withdraw_req", {31'b0, int_req}, 32'h0);
        step();
        chk("withdraw_noexit", {31'b0, int_exit}, 32'h0);
        chk("withdraw_curid", {20'b0, curid}, 32'd17);
        mode = 2'b11;

        // Preemption by a higher level while pending
        id = 12'd17; il = 8'd5;
        step();
        chk("pre_id17", {20'b0, int_id}, 32'd17);
        id = 12'd30; il = 8'd9;
        step();
        chk("pre_id30", {20'b0, int_id}, 32'd30);
        chk("pre_il9", {24'b0, int_il}, 32'd9);
        ack = 1'b1;
        step();
        ack = 1'b0; il = 8'd0;
        chk("pre_curid", {20'b0, curid}, 32'd30);
        chk("pre_exit", {31'b0, int_exit}, 32'h1);
        step();

        // Hardware-vectored with three wait states before grant
        hv = 1'b1; id = 12'd4; il = 8'd5;
        step();
        ack = 1'b1;
        step();
        ack = 1'b0; il = 8'd0;
        for (int i = 0; i < 3; i++) begin
            chk("vreq_hold", {31'b0, vec_req}, 32'h1);
            chk("vaddr_hold", vec_addr, 32'h2000_0050);
            step();
        end
        chk("vreq_hold", {31'b0, vec_req}, 32'h1);
        chk("vaddr_hold", vec_addr, 32'h2000_0050);
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk("vwait_noreq", {31'b0, vec_req}, 32'h0);
        chk("vwait_nojump", {31'b0, jump_vld}, 32'h0);
        rvld = 1'b1; rdata = 32'h0000_1235;
        step();
        rvld = 1'b0;
        chk("vjump_vld", {31'b0, jump_vld}, 32'h1);
        chk("vjump_pc", jump_pc, 32'h0000_1234);
        chk("vjump_err", {31'b0, jvec_err}, 32'h0);
        step();
        chk("vjump_1cyc", {31'b0, jump_vld}, 32'h0);

        // Vector fetch error with gnt and rvld together
        il = 8'd5;
        step();
        ack = 1'b1;
        step();
        ack = 1'b0; il = 8'd0;
        gnt = 1'b1; rvld = 1'b1; err = 1'b1; rdata = 32'hDEAD_BEEF;
        step();
        gnt = 1'b0; rvld = 1'b0; err = 1'b0;
        chk("verr_vld", {31'b0, jump_vld}, 32'h1);
        chk("verr_pc", jump_pc, 32'h0000_8000);
        chk("verr_flag", {31'b0, jvec_err}, 32'h1);
        step();

        // Reset while waiting for read data
        il = 8'd5;
        step();
        ack = 1'b1;
        step();
        ack = 1'b0; il = 8'd0; gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk("pre_rst_vwait", {31'b0, vec_req}, 32'h0);
        #2 rst_b = 1'b0;
        #1;
        chk("arst_int_req", {31'b0, int_req}, 32'h0);
        chk("arst_vec_req", {31'b0, vec_req}, 32'h0);
        chk("arst_jump_vld", {31'b0, jump_vld}, 32'h0);
        chk("arst_exit", {31'b0, int_exit}, 32'h0);
        chk("arst_curid", {20'b0, curid}, 32'h0);
        chk("arst_mode", {30'b0, cmode}, 32'h3);
        step();
        rst_b = 1'b1; hv = 1'b0;
        rvld = 1'b1; rdata = 32'h0000_4444;
        step();
        rvld = 1'b0;
        chk("late_rvld_nojump", {31'b0, jump_vld}, 32'h0);
        step();
        chk("late_rvld_nojump2", {31'b0, jump_vld}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
